// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first,
// repeated i_repeat+1 times back to back, with a start/ready handshake and sync abort.
module serial_pattern_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CNT_W    = 4,
    parameter bit          IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_repeat,
    input  logic             i_abort,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_bit,
    output logic             o_bit_vld,
    output logic             o_done
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    pat_d     = i_pattern;
                    shift_d   = i_pattern;
                    bit_cnt_d = LAST_BIT;
                    rep_cnt_d = i_repeat;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (i_abort) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                    state_d   = IDLE;
                end else if (bit_cnt_q == '0) begin
                    // Reload on the last bit so the next pass starts with no gap cycle.
                    if (rep_cnt_q != '0) begin
                        shift_d   = pat_q;
                        bit_cnt_d = LAST_BIT;
                        rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    end else begin
                        shift_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign o_ready   = (state_q == IDLE);
    assign o_busy    = (state_q != IDLE);
    assign o_bit_vld = (state_q == SHIFT);
    assign o_bit     = (state_q == SHIFT) ? shift_q[WIDTH-1] : IDLE_BIT;
    assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: stimulus queues expected bits, a negedge
// monitor pops and compares them and runs a 0->1 detector model on the serial stream.
module tb_serial_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] i_pattern = '0;
    logic [CNT_W-1:0] i_repeat = '0;
    logic             i_abort = 1'b0;
    logic             o_ready, o_busy, o_bit, o_bit_vld, o_done;

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_start   (i_start),
        .i_pattern (i_pattern),
        .i_repeat  (i_repeat),
        .i_abort   (i_abort),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_bit     (o_bit),
        .o_bit_vld (o_bit_vld),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc_now = 0;
    int   acc_cyc = 0;
    int   done_cnt = 0;
    int   det_cnt = 0;
    logic exp_q[$];
    logic prev_bit = 1'b0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc_now++;

    // Monitor: every valid bit must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_bit = 1'b0;
            prev_vld = 1'b0;
        end else begin
            checks++;
            if (o_bit_vld) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bit_unexpected got=%0b want=none t=%0t", o_bit, $time);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    if (o_bit !== e) begin
                        errors++;
                        $display("FAIL bit_seq got=%0b want=%0b t=%0t", o_bit, e, $time);
                    end
                end
                if (prev_vld && !prev_bit && o_bit) det_cnt++;
            end else if (o_bit !== 1'b0) begin
                errors++;
                $display("FAIL idle_bit got=%0b want=0 t=%0t", o_bit, $time);
            end
            if (o_done) done_cnt++;
            prev_bit = o_bit;
            prev_vld = o_bit_vld;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge (cycle 1 of the transfer).
    task automatic send(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep,
                        input logic abort_too, input int nbits);
        int n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_start", int'(o_ready), 1);
        for (int i = 0; i < nbits; i++) exp_q.push_back(pat[WIDTH-1-(i % WIDTH)]);
        i_start   = 1'b1;
        i_pattern = pat;
        i_repeat  = rep;
        i_abort   = abort_too;
        @(posedge clk); #1;
        acc_cyc   = cyc_now;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_pattern = ~pat;
        i_repeat  = ~rep;
    endtask

    task automatic wait_done(input int exp_lat);
        int  n = 0;
        bit  seen = 0;
        int  lat = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (o_done) begin
                seen = 1;
                lat = cyc_now - acc_cyc + 1;
            end
        end
        if (!seen) lat = -1;
        chk("done_latency", lat, exp_lat);
        chk("done_busy", int'(o_busy), 1);
        chk("done_not_ready", int'(o_ready), 0);
        chk("done_vld_low", int'(o_bit_vld), 0);
        @(negedge clk);
        chk("ready_after_done", int'(o_ready), 1);
        chk("done_one_cycle", int'(o_done), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 1);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_bit"}, int'(o_bit), 0);
        chk({tag, "_vld"}, int'(o_bit_vld), 0);
        chk({tag, "_done"}, int'(o_done), 0);
    endtask

    task automatic test_a5();
        int d0 = done_cnt;
        send(8'hA5, 4'd0, 1'b0, 8);
        wait_done(9);
        chk("a5_done_count", done_cnt - d0, 1);
        chk("a5_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int q0;
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int det0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: single pass of A5
        test_a5();

        // 2: three passes of 01, abort raised together with start is ignored
        d0 = done_cnt;
        send(8'h01, 4'd2, 1'b1, 24);
        wait_done(25);
        chk("rep2_done_count", done_cnt - d0, 1);
        chk("rep2_queue_empty", exp_q.size(), 0);

        // 3: start pulse during a busy transfer is dropped
        d0 = done_cnt;
        send(8'h00, 4'd0, 1'b0, 8);
        repeat (2) begin @(posedge clk); #1; end
        i_start   = 1'b1;
        i_pattern = 8'hFF;
        @(posedge clk); #1;
        i_start   = 1'b0;
        wait_done(9);
        repeat (12) begin @(posedge clk); #1; end
        chk("busy_start_done_count", done_cnt - d0, 1);
        chk("busy_start_queue_empty", exp_q.size(), 0);

        // 4: abort during the 4th bit of C3
        d0 = done_cnt;
        send(8'hC3, 4'd0, 1'b0, 4);
        repeat (3) begin @(posedge clk); #1; end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(o_ready), 1);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_done", int'(o_done), 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue_empty", exp_q.size(), 0);

        // 5: reset in the middle of the first pass of 5A
        d0 = done_cnt;
        send(8'h5A, 4'd1, 1'b0, 5);
        repeat (5) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) begin @(posedge clk); #1; end
        chk_reset_outputs("held_reset");
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_queue_empty", exp_q.size(), 0);
        test_a5();

        // 6: 0->1 detector model over two passes of 0100_1101
        det0 = det_cnt;
        d0 = done_cnt;
        send(8'b0100_1101, 4'd1, 1'b0, 16);
        wait_done(17);
        chk("detect_count", det_cnt - det0, 6);
        chk("detect_done_count", done_cnt - d0, 1);

        // Max repeat count: 16 passes without counter underflow
        d0 = done_cnt;
        send(8'h81, 4'd15, 1'b0, 128);
        wait_done(129);
        chk("maxrep_done_count", done_cnt - d0, 1);
        chk("maxrep_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
